// File: rtl/dac_wr_ctrl.sv
// Scales a 0..1000 setpoint to an 8-bit code and writes it to a DAC0832-style
// parallel DAC using a tick-timed CS/WR/XFER strobe sequence.
module dac_wr_ctrl #(
    parameter int CLK_DIV      = 50,
    parameter int WR_LOW_TICKS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [10:0] value,
    output logic        busy,
    output logic        done,
    output logic [7:0]  dac_data,
    output logic        cs_n,
    output logic        wr_n,
    output logic        xfer_n,
    output logic [7:0]  led
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam int TK_W  = $clog2(WR_LOW_TICKS + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCALE = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_XFER  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TK_W-1:0]  tk_q, tk_d;
    logic [10:0]      value_q;
    logic             tick;
    logic             busy_q, done_q, cs_n_q, wr_n_q, xfer_n_q;
    logic [7:0]       dac_q, led_q;

    // Round-half-up of min(v,1000)*255/1000; worst case 255500 fits in 18 bits.
    function automatic logic [7:0] scale_code(input logic [10:0] v);
        logic [9:0]  vc;
        logic [17:0] prod;
        vc   = (v > 11'd1000) ? 10'd1000 : v[9:0];
        prod = 18'(vc) * 18'd255 + 18'd500;
        return 8'(prod / 18'd1000);
    endfunction

    assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tk_d    = tk_q;
        case (state_q)
            S_IDLE:  if (req) state_d = S_SCALE;
            S_SCALE: state_d = S_SETUP;
            S_SETUP: if (tick) state_d = S_WRITE;
            S_WRITE: if (tick && tk_q == TK_W'(WR_LOW_TICKS - 1)) state_d = S_HOLD;
            S_HOLD:  if (tick) state_d = S_XFER;
            S_XFER:  if (tick) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Timing restarts from zero whenever a new state is entered.
        if (state_d != state_q) begin
            cnt_d = '0;
            tk_d  = '0;
        end else if (tick) begin
            cnt_d = '0;
            tk_d  = tk_q + TK_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tk_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            xfer_n_q <= 1'b1;
            dac_q    <= 8'd0;
            led_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tk_q     <= tk_d;
            // Strobes decoded from the next state so each pin is a clean flop output.
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
            cs_n_q   <= !(state_d == S_SETUP || state_d == S_WRITE || state_d == S_HOLD);
            wr_n_q   <= (state_d != S_WRITE);
            xfer_n_q <= (state_d != S_XFER);
            if (state_q == S_SCALE) begin
                dac_q <= scale_code(value_q);
                led_q <= scale_code(value_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && req) value_q <= value;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign dac_data = dac_q;
    assign cs_n     = cs_n_q;
    assign wr_n     = wr_n_q;
    assign xfer_n   = xfer_n_q;
    assign led      = led_q;

endmodule
